// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - magic-word framed UART payload decoder with bit-serial CRC-16 check
module uart_frame_decoder #(
    parameter int PAYLOAD_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       payload_valid,
    output logic                       crc_err,
    output logic [15:0]                frame_count,
    output logic [15:0]                err_count,
    output logic                       busy
);
    localparam int N  = 4 + PAYLOAD_BYTES;
    localparam int WB = 8 * N;
    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = $clog2(WB + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WB);
    localparam logic [3:0]    PB_LAST   = 4'(PAYLOAD_BYTES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT0, HUNT1, HUNT2, HUNT3, PAYLOAD, CRC_HI, CRC_LO, CHECK
    } state_t;

    state_t          state, next_state;
    logic [PW-1:0]   frame_buf;
    logic [15:0]     rx_crc;
    logic [15:0]     crc;
    logic [15:0]     crc_next;
    logic [WB-1:0]   shreg;
    logic [WB-1:0]   word;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      byte_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            in_frame;
    logic            timeout;
    logic            crc_done;
    logic            crc_ok;
    logic            err_inc;
    logic            fb;

    // CRC input word is {b(N-1)..b0}; the magic occupies the low 32 bits
    always_comb begin
        word       = '0;
        word[31:0] = 32'h00AD_BBDA;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            word[8*(4+i) +: 8] = frame_buf[8*(PAYLOAD_BYTES-1-i) +: 8];
        end
    end

    always_comb begin
        fb       = crc[15] ^ shreg[WB-1];
        crc_next = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end

    assign in_frame = (state != HUNT0) && (state != CHECK);
    assign timeout  = in_frame && !rx_valid && (idle_cnt == IDLE_LAST);
    assign crc_done = (state == CHECK) && (bit_cnt == BIT_LAST);
    assign crc_ok   = (crc == rx_crc);
    assign err_inc  = timeout || ((state == CHECK) && rx_valid) || (crc_done && !crc_ok);
    assign busy     = (state == CHECK);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state <= HUNT0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = HUNT0;
        end else begin
            unique case (state)
                HUNT0:   if (rx_valid && rx_byte == 8'hDA) next_state = HUNT1;
                HUNT1:   if (rx_valid) next_state = (rx_byte == 8'hBB) ? HUNT2 :
                                                    (rx_byte == 8'hDA) ? HUNT1 : HUNT0;
                HUNT2:   if (rx_valid) next_state = (rx_byte == 8'hAD) ? HUNT3 :
                                                    (rx_byte == 8'hDA) ? HUNT1 : HUNT0;
                HUNT3:   if (rx_valid) next_state = (rx_byte == 8'h00) ? PAYLOAD :
                                                    (rx_byte == 8'hDA) ? HUNT1 : HUNT0;
                PAYLOAD: if (rx_valid && byte_cnt == PB_LAST) next_state = CRC_HI;
                CRC_HI:  if (rx_valid) next_state = CRC_LO;
                CRC_LO:  if (rx_valid) next_state = CHECK;
                CHECK:   if (crc_done) next_state = HUNT0;
                default: next_state = HUNT0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            payload       <= '0;
            payload_valid <= 1'b0;
            crc_err       <= 1'b0;
            frame_count   <= '0;
            err_count     <= '0;
            frame_buf     <= '0;
            rx_crc        <= '0;
            crc           <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
        end else begin
            payload_valid <= 1'b0;
            crc_err       <= 1'b0;
            // Saturating so a long quiet line never wraps back into range
            if (rx_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (err_inc) begin
                err_count <= err_count + 1'b1;
            end
            if (state != PAYLOAD) begin
                byte_cnt <= '0;
            end
            unique case (state)
                PAYLOAD: if (rx_valid) begin
                    frame_buf <= (frame_buf << 8) | PW'(rx_byte);
                    byte_cnt  <= byte_cnt + 1'b1;
                end
                CRC_HI: if (rx_valid) begin
                    rx_crc[15:8] <= rx_byte;
                end
                CRC_LO: if (rx_valid) begin
                    rx_crc[7:0] <= rx_byte;
                    shreg       <= word;
                    crc         <= 16'hFFFF;
                    bit_cnt     <= '0;
                end
                CHECK: begin
                    if (!crc_done) begin
                        crc     <= crc_next;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (crc_ok) begin
                        payload       <= frame_buf;
                        payload_valid <= 1'b1;
                        frame_count   <= frame_count + 1'b1;
                    end else begin
                        crc_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - directed self-checking bench for uart_frame_decoder
module tb_uart_frame_decoder;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [15:0] payload;
    logic        payload_valid;
    logic        crc_err;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    logic        busy;

    int checks_total  = 0;
    int checks_passed = 0;
    int pv_n, pv_cyc, ce_n, ce_cyc;
    logic busy1, busy50;

    uart_frame_decoder #(.PAYLOAD_BYTES(2), .TIMEOUT_CYCLES(4096)) dut (
        .CLK(CLK), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .payload(payload), .payload_valid(payload_valid), .crc_err(crc_err),
        .frame_count(frame_count), .err_count(err_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference CRC-16/0x8005 over W = {b5..b0}, most significant bit first
    function automatic logic [15:0] ref_crc(input logic [7:0] p_hi, input logic [7:0] p_lo);
        logic [7:0]  b [6];
        logic [15:0] c;
        logic        f;
        b[0] = 8'hDA; b[1] = 8'hBB; b[2] = 8'hAD; b[3] = 8'h00; b[4] = p_hi; b[5] = p_lo;
        c = 16'hFFFF;
        for (int i = 5; i >= 0; i--) begin
            for (int j = 7; j >= 0; j--) begin
                f = c[15] ^ b[i][j];
                c = {c[14:0], 1'b0};
                if (f) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        repeat (159) @(posedge CLK);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
    endtask

    // Starts in cycle 1 after the CRC_LO byte; optionally injects a byte at cycle inj
    task automatic watch(input int inj);
        pv_n = 0; pv_cyc = -1; ce_n = 0; ce_cyc = -1; busy1 = 1'b0; busy50 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (payload_valid) begin pv_n++; pv_cyc = k; end
            if (crc_err) begin ce_n++; ce_cyc = k; end
            if (k == 1) busy1 = busy;
            if (k == 50) busy50 = busy;
            if (inj != 0 && k == inj) begin
                rx_valid = 1'b1;
                rx_byte  = 8'h5A;
            end else begin
                rx_valid = 1'b0;
            end
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] p_hi, input logic [7:0] p_lo,
                              input logic [7:0] lo_flip, input int inj);
        logic [15:0] c;
        c = ref_crc(p_hi, p_lo);
        send_gap(8'hDA); send_gap(8'hBB); send_gap(8'hAD); send_gap(8'h00);
        send_gap(p_hi);  send_gap(p_lo);  send_gap(c[15:8]);
        send_byte(c[7:0] ^ lo_flip);
        watch(inj);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;
        check("rst_payload", 32'(payload), 32'h0);
        check("rst_pv", 32'(payload_valid), 32'h0);
        check("rst_crc_err", 32'(crc_err), 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        send_frame(8'h12, 8'h34, 8'h00, 0);
        check("ok_pv_cycle", 32'(pv_cyc), 32'd50);
        check("ok_pv_pulses", 32'(pv_n), 32'd1);
        check("ok_crc_err_pulses", 32'(ce_n), 32'd0);
        check("ok_busy_c1", 32'(busy1), 32'd1);
        check("ok_busy_c50", 32'(busy50), 32'd0);
        check("ok_payload", 32'(payload), 32'h1234);
        check("ok_frame_count", 32'(frame_count), 32'd1);
        check("ok_err_count", 32'(err_count), 32'd0);

        pulse_reset();
        send_frame(8'h12, 8'h34, 8'h01, 0);
        check("bad_ce_cycle", 32'(ce_cyc), 32'd50);
        check("bad_ce_pulses", 32'(ce_n), 32'd1);
        check("bad_pv_pulses", 32'(pv_n), 32'd0);
        check("bad_payload", 32'(payload), 32'h0);
        check("bad_err_count", 32'(err_count), 32'd1);
        check("bad_frame_count", 32'(frame_count), 32'd0);

        pulse_reset();
        send_gap(8'hDA);
        send_frame(8'h12, 8'h34, 8'h00, 0);
        check("pre_pv_pulses", 32'(pv_n), 32'd1);
        check("pre_payload", 32'(payload), 32'h1234);
        check("pre_frame_count", 32'(frame_count), 32'd1);
        check("pre_err_count", 32'(err_count), 32'd0);

        pulse_reset();
        send_gap(8'hDA); send_gap(8'hBB); send_gap(8'hAD); send_gap(8'h00);
        send_gap(8'h12); send_byte(8'h34);
        repeat (4096 + 100) @(posedge CLK);
        #1;
        check("to_err_count_stall", 32'(err_count), 32'd1);
        send_frame(8'hAB, 8'hCD, 8'h00, 0);
        check("to_pv_pulses", 32'(pv_n), 32'd1);
        check("to_err_count", 32'(err_count), 32'd1);
        check("to_payload", 32'(payload), 32'hABCD);
        check("to_frame_count", 32'(frame_count), 32'd1);

        pulse_reset();
        send_frame(8'h12, 8'h34, 8'h00, 10);
        check("drop_pv_cycle", 32'(pv_cyc), 32'd50);
        check("drop_err_count", 32'(err_count), 32'd1);
        check("drop_payload", 32'(payload), 32'h1234);
        check("drop_frame_count", 32'(frame_count), 32'd1);

        send_gap(8'hDA); send_gap(8'hBB); send_gap(8'hAD); send_gap(8'h00);
        send_byte(8'h55);
        pulse_reset();
        check("mid_rst_payload", 32'(payload), 32'h0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        watch(0);
        check("mid_rst_no_pulse", 32'(pv_n + ce_n), 32'd0);
        send_frame(8'h55, 8'hAA, 8'h00, 0);
        check("mid_rst_pv_pulses", 32'(pv_n), 32'd1);
        check("mid_rst_new_payload", 32'(payload), 32'h55AA);
        check("mid_rst_new_frame_count", 32'(frame_count), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
